// File: rtl/mem_responder.sv
// mem_responder: word-organized memory target with a fixed number of wait
// states before each response. Accesses are latched in IDLE, held through
// WAIT, and completed in RESP with a one-cycle ready pulse (plus err for
// misaligned or out-of-range addresses).
module mem_responder #(
   parameter int unsigned ADDR_BITS   = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int unsigned  DEPTH   = 1 << (ADDR_BITS - 2);
   localparam logic [3:0]   LP_WAIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic                   r_we;
   logic [31:0]            r_addr;
   logic [31:0]            r_wdata;
   logic [31:0]            r_rdata;
   logic                   r_ready;
   logic                   r_busy;
   logic                   r_err;

   // Big-endian word store: byte address A lives in bits 31:24 of the word
   // at A[ADDR_BITS-1:2]. Only whole words are accessed, so words are kept
   // exactly as written.
   logic [31:0]            r_mem [DEPTH];

   logic                   w_reject;
   logic [ADDR_BITS-3:0]   w_word_idx;
   logic [31:0]            w_rd_word;
   logic                   w_wr_en;

   // Address decode and rejection on the latched request only
   always_comb begin
      w_reject   = (r_addr[1:0] != 2'b00) || ((r_addr >> ADDR_BITS) != 32'd0);
      w_word_idx = r_addr[ADDR_BITS-1:2];
      w_rd_word  = r_mem[w_word_idx];
      w_wr_en    = (r_state == S_RESP) && r_we && !w_reject;
   end

   // Storage update at the RESP edge; deliberately not reset so contents
   // survive reset (reset forces IDLE, which also blocks any pending write)
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_word_idx] <= r_wdata;
      end
   end

   // Control FSM with registered ready/busy/err/rdata
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= LP_WAIT;
                  r_busy  <= 1'b1;
                  r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               // Counter hits 0 on the same edge that enters RESP, giving
               // exactly WAIT_CYCLES cycles in WAIT.
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               r_ready <= 1'b1;
               r_err   <= w_reject;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
               if (w_reject) begin
                  r_rdata <= '0;
               end else if (!r_we) begin
                  r_rdata <= w_rd_word;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rdata = r_rdata;
   assign ready = r_ready;
   assign busy  = r_busy;
   assign err   = r_err;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8, SHALL set byte address space to 2^ADDR_BITS bytes (2^(ADDR_BITS-2) words).
REQ-002 Parameter WAIT_CYCLES, default 2, range 0-15, SHALL set the wait states inserted before each response.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  1  SHALL be the initiator's access request, sampled only in IDLE.
REQ-006 Port we  input  1  SHALL mark the request as a write (1) or a read (0).
REQ-007 Port addr  input  32  SHALL be the byte address of the access.
REQ-008 Port wdata  input  32  SHALL be the write data.
REQ-009 Port rdata  output  32  SHALL be the read data, valid when ready=1 and err=0 for a read.
REQ-010 Port ready  output  1  SHALL be a one-cycle pulse marking transaction completion.
REQ-011 Port busy  output  1  SHALL be 1 in every state except IDLE.
REQ-012 Port err  output  1  SHALL be 1 together with ready for a rejected access, else 0.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, it SHALL latch addr, we and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT (or to RESP when WAIT_CYCLES=0).
REQ-015 In WAIT, it SHALL decrement the counter each cycle and go to RESP in the cycle after the counter reaches 0.
REQ-016 Latency: for req sampled at edge N, ready SHALL be 1 in the cycle after edge N+1+WAIT_CYCLES.
REQ-017 In RESP, it SHALL assert ready for exactly one cycle, perform the access using the latched values, and return to IDLE.
REQ-018 req, we, addr and wdata SHALL be ignored outside IDLE; input changes during WAIT SHALL NOT affect the transaction in progress.
REQ-019 An access is rejected when latched addr[1:0]!=0 or when any bit addr[31:ADDR_BITS] is nonzero.
REQ-020 A rejected access SHALL set err=1 with ready, SHALL NOT write storage, and SHALL drive rdata=0.
REQ-021 Storage SHALL be word-organized and big-endian: byte address A SHALL hold bits 31:24 of the word at A[ADDR_BITS-1:2].
REQ-022 An accepted write SHALL update the word at the RESP edge; rdata SHALL keep its previous value.
REQ-023 An accepted read SHALL load rdata with the stored word at the RESP edge.
REQ-024 rdata SHALL hold its value until the next accepted read, rejected access, or reset.
REQ-025 Back-to-back: a req held high across ready SHALL be accepted in the IDLE cycle after RESP, giving a minimum spacing of WAIT_CYCLES+2 cycles between ready pulses.
REQ-026 A read issued right after a write to the same address SHALL return the newly written data.

Reset
REQ-027 While reset=1, the FSM SHALL be IDLE, the counter 0, and ready, busy, err and rdata 0, independent of clk.
REQ-028 Reset asserted mid-transaction SHALL abort it: no storage write, no ready pulse.
REQ-029 Storage contents SHALL NOT be cleared by reset; benches SHALL write a location before reading it.
REQ-030 The first req SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-031 WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF, then read 0x10 -> ready 3 cycles after each req edge, err=0, rdata=0xDEADBEEF.
REQ-032 WAIT_CYCLES=0: req held high for 4 transactions -> ready pulses every 2 cycles, busy=1 only in RESP.
REQ-033 Read addr=0x12 -> err=1 with ready, rdata=0; following read of 0x10 -> 0xDEADBEEF unchanged.
REQ-034 Write addr=0x100 (ADDR_BITS=8) -> err=1, and words 0x00-0xFC stay unchanged.
REQ-035 Write 0x11223344 to 0x20, assert reset during WAIT -> outputs 0 immediately, no ready; after reset, read 0x20 -> prior contents (not 0x11223344).
REQ-036 Change addr and wdata during WAIT of a write to 0x04 -> only word 0x04 is written, with the originally latched wdata.
